vertex_stream_transform: RTL and testbench

- Streaming successor to the single-vertex MVP transform path.
- Holds a double-buffered 4x4 MVP matrix loaded over a write port.
- Accepts a valid/ready stream of float vertices and computes w = row3·v.
- For each vertex: perspective divide, float-to-int, viewport offset, then saturation to a parametrised coordinate width.
- Results go through an output FIFO with clip and offscreen flags, so the rasteriser can consume bursts of vertices without re-triggering matrix setup.

---
 rtl/vertex_stream_transform.sv | 234 +++++++++++++++++++++++
 tb/tb_vertex_stream_transform.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vertex_stream_transform.sv
// vertex_stream_transform: streaming MVP transform with perspective divide, viewport mapping and an output FIFO
module vertex_stream_transform #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int COORD_W   = 16,
  parameter int OUT_DEPTH = 4,
  parameter int DIV_LAT   = 10,
  parameter int F2I_LAT   = 6
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      mat_we_i,
  input  logic [1:0]                mat_row_i,
  input  logic [1:0]                mat_col_i,
  input  logic [31:0]               mat_data_i,
  input  logic                      mat_commit_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               in_x_i,
  input  logic [31:0]               in_y_i,
  input  logic [31:0]               in_z_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [COORD_W-1:0] out_x_o,
  output logic signed [COORD_W-1:0] out_y_o,
  output logic signed [COORD_W-1:0] out_z_o,
  output logic                      out_clipped_o,
  output logic                      out_offscreen_o,
  output logic                      busy_o,
  output logic [15:0]               vert_count_o
);
  localparam int MULT_LAT = 2;
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(DIV_LAT + F2I_LAT + MULT_LAT + 4);
  localparam int EW = 3 * COORD_W + 2;
  localparam logic signed [31:0] SMAX = (32'sd1 <<< (COORD_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SMIN = -SMAX - 32'sd1;
  typedef enum logic [3:0] {
    S_IDLE, S_MULT_START, S_MULT, S_CLIP_CHK, S_DIV, S_DIV_WAIT, S_F2I, S_F2I_WAIT, S_SAMPLE, S_PUSH
  } state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         sub;
  logic [31:0]        act_q [4][4];
  logic [31:0]        shd_q [4][4];
  logic               pend_q;
  logic [31:0]        v_q [3];
  logic [31:0]        c_q [4];
  logic [31:0]        q_q [3];
  logic signed [31:0] i_q [3];
  logic [COORD_W-1:0] r_q [3];
  logic               clip_q, off_q;
  logic [15:0]        vc_q;
  logic [EW-1:0]      mem_q [OUT_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        fc_q;
  logic               push, pop;
  logic signed [31:0] s_d;
  logic               off_d;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [24:0] p;
    logic [7:0]  e;
    p = 25'(({24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]}) >> 23);
    e = a[30:23] + b[30:23] - 8'd127 + {7'd0, p[24]};
    return (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 32'd0 :
           {a[31] ^ b[31], e, p[24] ? p[23:1] : p[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [27:0] mx, my, s;
    logic [7:0]  e;
    x = (a[30:0] < b[30:0]) ? b : a;
    y = (a[30:0] < b[30:0]) ? a : b;
    if (y[30:23] == 8'd0) return x;
    mx = {2'b01, x[22:0], 3'b0};
    my = {2'b01, y[22:0], 3'b0} >> (x[30:23] - y[30:23]);
    s  = (x[31] == y[31]) ? mx + my : mx - my;
    e  = x[30:23];
    if (s == 28'd0) return 32'd0;
    if (s[27]) begin
      s = s >> 1;
      e = e + 8'd1;
    end
    for (int i = 0; i < 27; i++)
      if (!s[26]) begin
        s = s << 1;
        e = e - 8'd1;
      end
    return {x[31], e, s[25:3]};
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic [24:0] q;
    logic [7:0]  e;
    q = 25'({1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]});
    e = a[30:23] - b[30:23] + 8'd126 + {7'd0, q[24]};
    return (a[30:23] == 8'd0) ? 32'd0 : {a[31] ^ b[31], e, q[24] ? q[23:1] : q[22:0]};
  endfunction

  // Round half away from zero; magnitudes beyond 32 bits clamp to the signed range.
  function automatic logic [31:0] f2i(input logic [31:0] a);
    logic [63:0] m;
    logic [31:0] r;
    m = {40'd0, 1'b1, a[22:0]};
    if (a[30:23] >= 8'd158) return a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    r = (a[30:23] < 8'd126) ? 32'd0 :
        (a[30:23] >= 8'd150) ? 32'(m << (a[30:23] - 8'd150)) :
        32'((m + (64'd1 << (8'd149 - a[30:23]))) >> (8'd150 - a[30:23]));
    return a[31] ? -r : r;
  endfunction

  function automatic logic [COORD_W-1:0] sat(input logic signed [31:0] v);
    return v > SMAX ? SMAX[COORD_W-1:0] : v < SMIN ? SMIN[COORD_W-1:0] : v[COORD_W-1:0];
  endfunction

  assign sub         = cnt_q[1:0];
  assign busy_o      = state_q != S_IDLE;
  assign vert_count_o = vc_q;
  assign in_ready_o  = state_q == S_IDLE && !pend_q && fc_q < (AW+1)'(OUT_DEPTH);
  assign out_valid_o = fc_q != '0;
  assign push        = state_q == S_PUSH;
  assign pop         = out_valid_o && out_ready_i;
  assign {out_clipped_o, out_offscreen_o, out_x_o, out_y_o, out_z_o} = mem_q[rd_q];

  // Viewport offset and offscreen test for the coordinate currently being sampled (x, y, then z).
  always_comb begin
    s_d   = i_q[sub] + (sub == 2'd0 ? 32'(SCREEN_W / 2) : sub == 2'd1 ? 32'(SCREEN_H / 2) : 32'sd0);
    off_d = sub != 2'd2 && (s_d < 0 || s_d >= (sub == 2'd0 ? SCREEN_W : SCREEN_H));
  end

  // Shadow/active matrix pair; a commit seen while busy waits until the FSM is idle again.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          act_q[i][j] <= (i == j) ? 32'h3f80_0000 : 32'd0;
          shd_q[i][j] <= (i == j) ? 32'h3f80_0000 : 32'd0;
        end
      pend_q <= 1'b0;
    end else begin
      if (mat_we_i) shd_q[mat_row_i][mat_col_i] <= mat_data_i;
      if (state_q == S_IDLE && (mat_commit_i || pend_q)) act_q <= shd_q;
      pend_q <= state_q != S_IDLE && (pend_q || mat_commit_i);
    end
  end

  // Per-vertex sequencer: transform, clip test, divide, convert, map to screen, push.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vc_q    <= '0;
      clip_q  <= 1'b0;
      off_q   <= 1'b0;
      for (int k = 0; k < 4; k++) c_q[k] <= '0;
      for (int k = 0; k < 3; k++) begin
        v_q[k] <= '0;
        q_q[k] <= '0;
        i_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (in_valid_i && in_ready_o) begin
          v_q[0]  <= in_x_i;
          v_q[1]  <= in_y_i;
          v_q[2]  <= in_z_i;
          vc_q    <= vc_q + 16'd1;
          state_q <= S_MULT_START;
        end
        S_MULT_START: begin
          for (int j = 0; j < 4; j++)
            c_q[j] <= fadd(fadd(fmul(act_q[j][0], v_q[0]), fmul(act_q[j][1], v_q[1])),
                           fadd(fmul(act_q[j][2], v_q[2]), act_q[j][3]));
          cnt_q   <= '0;
          state_q <= S_MULT;
        end
        S_MULT: begin
          cnt_q   <= cnt_q == CW'(MULT_LAT - 1) ? '0 : cnt_q + 1'b1;
          state_q <= cnt_q == CW'(MULT_LAT - 1) ? S_CLIP_CHK : S_MULT;
        end
        S_CLIP_CHK: begin
          clip_q  <= c_q[3][31] || c_q[3][30:0] == 31'd0;
          off_q   <= 1'b0;
          for (int k = 0; k < 3; k++) r_q[k] <= '0;
          state_q <= (c_q[3][31] || c_q[3][30:0] == 31'd0) ? S_PUSH : S_DIV;
        end
        S_DIV: begin
          q_q[sub] <= fdiv(c_q[sub], c_q[3]);
          cnt_q    <= cnt_q == CW'(2) ? '0 : cnt_q + 1'b1;
          state_q  <= cnt_q == CW'(2) ? S_DIV_WAIT : S_DIV;
        end
        S_DIV_WAIT: begin
          cnt_q   <= cnt_q == CW'(DIV_LAT - 1) ? '0 : cnt_q + 1'b1;
          state_q <= cnt_q == CW'(DIV_LAT - 1) ? S_F2I : S_DIV_WAIT;
        end
        S_F2I: begin
          i_q[sub] <= $signed(f2i(q_q[sub]));
          cnt_q    <= cnt_q == CW'(2) ? '0 : cnt_q + 1'b1;
          state_q  <= cnt_q == CW'(2) ? S_F2I_WAIT : S_F2I;
        end
        S_F2I_WAIT: begin
          cnt_q   <= cnt_q == CW'(F2I_LAT - 1) ? '0 : cnt_q + 1'b1;
          state_q <= cnt_q == CW'(F2I_LAT - 1) ? S_SAMPLE : S_F2I_WAIT;
        end
        S_SAMPLE: begin
          r_q[sub] <= sat(s_d);
          off_q    <= sub == 2'd0 ? off_d : (off_q | off_d);
          cnt_q    <= cnt_q == CW'(2) ? '0 : cnt_q + 1'b1;
          state_q  <= cnt_q == CW'(2) ? S_PUSH : S_SAMPLE;
        end
        S_PUSH: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // First-word-fall-through output FIFO; simultaneous push and pop keep the count.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < OUT_DEPTH; k++) mem_q[k] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fc_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= {clip_q, off_q, r_q[0], r_q[1], r_q[2]};
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      fc_q <= fc_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_vertex_stream_transform.sv
// tb_vertex_stream_transform: directed vector table plus handshake, commit and reset sequences
module tb_vertex_stream_transform;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mat_we = 1'b0, mat_commit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]  mat_row = '0, mat_col = '0;
  logic [31:0] mat_data = '0, in_x = '0, in_y = '0, in_z = '0;
  logic        in_ready, out_valid, oclip, ooff, busy;
  logic [15:0] ox, oy, oz, vcnt;
  logic        b_in_ready, b_out_valid, bclip, boff, bbusy;
  logic [7:0]  bx, by, bz;
  logic [15:0] bvcnt;
  int checks = 0, failures = 0;

  typedef struct {
    logic [31:0] m33, x, y, z;
    int ex, ey, ez, bx;
    logic clip, off;
  } vec_t;
  vec_t tv[8];
  logic [31:0] fx[6];
  int lat[8];

  always #5 clk = ~clk;

  vertex_stream_transform dut (
    .clock_i(clk), .reset_i(rst), .mat_we_i(mat_we), .mat_row_i(mat_row), .mat_col_i(mat_col),
    .mat_data_i(mat_data), .mat_commit_i(mat_commit), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_x_i(in_x), .in_y_i(in_y), .in_z_i(in_z), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_x_o(ox), .out_y_o(oy), .out_z_o(oz), .out_clipped_o(oclip), .out_offscreen_o(ooff),
    .busy_o(busy), .vert_count_o(vcnt));

  vertex_stream_transform #(.COORD_W(8)) dut8 (
    .clock_i(clk), .reset_i(rst), .mat_we_i(mat_we), .mat_row_i(mat_row), .mat_col_i(mat_col),
    .mat_data_i(mat_data), .mat_commit_i(mat_commit), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_x_i(in_x), .in_y_i(in_y), .in_z_i(in_z), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .out_x_o(bx), .out_y_o(by), .out_z_o(bz), .out_clipped_o(bclip), .out_offscreen_o(boff),
    .busy_o(bbusy), .vert_count_o(bvcnt));

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic wr_m33(input logic [31:0] d);
    @(negedge clk);
    mat_we = 1'b1; mat_row = 2'd3; mat_col = 2'd3; mat_data = d;
    @(negedge clk);
    mat_we = 1'b0;
  endtask

  task automatic commit;
    @(negedge clk);
    mat_commit = 1'b1;
    @(negedge clk);
    mat_commit = 1'b0;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_y = y; in_z = z;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  task automatic pop;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc, popd, n;
    logic hs, pp;
    tv[0] = '{32'h3f800000, 32'h41200000, 32'h41a00000, 32'h0,       330, 260,  0,  127, 1'b0, 1'b0};
    tv[1] = '{32'h40000000, 32'h42c80000, 32'hc2200000, 32'h41000000, 370, 220,  4,  127, 1'b0, 1'b0};
    tv[2] = '{32'hbf800000, 32'h40a00000, 32'h40a00000, 32'h40a00000, 0,   0,    0,  0,   1'b1, 1'b0};
    tv[3] = '{32'h3f800000, 32'h447a0000, 32'h0,       32'h0,       1320, 240,  0,  127, 1'b0, 1'b1};
    tv[4] = '{32'h3f800000, 32'h40300000, 32'hc0500000, 32'hc0e00000, 323, 237, -7,  127, 1'b0, 1'b0};
    tv[5] = '{32'h40800000, 32'h3f800000, 32'hbf800000, 32'h40400000, 320, 240,  1,  127, 1'b0, 1'b0};
    tv[6] = '{32'h3f800000, 32'h0,       32'hc3960000, 32'h0,       320, -60,  0,  127, 1'b0, 1'b1};
    tv[7] = '{32'h3f800000, 32'hc47a0000, 32'h0,       32'h0,       -680, 240, 0, -128, 1'b0, 1'b1};
    fx = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000, 32'h40c00000};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vert_count", vcnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      wr_m33(tv[i].m33);
      commit;
      send(tv[i].x, tv[i].y, tv[i].z);
      wait_out(lat[i]);
      chk($sformatf("v%0d_x", i), int'($signed(ox)), tv[i].ex);
      chk($sformatf("v%0d_y", i), int'($signed(oy)), tv[i].ey);
      chk($sformatf("v%0d_z", i), int'($signed(oz)), tv[i].ez);
      chk($sformatf("v%0d_clip", i), oclip, tv[i].clip);
      chk($sformatf("v%0d_off", i), ooff, tv[i].off);
      chk($sformatf("v%0d_sat8_x", i), int'($signed(bx)), tv[i].bx);
      chk($sformatf("v%0d_vert_count", i), vcnt, i + 1);
      pop;
      chk($sformatf("v%0d_empty", i), out_valid, 0);
    end
    chk("clip_faster", int'(lat[2] < lat[0]), 1);

    acc = 0; popd = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = acc < 6;
      if (acc < 6) begin in_x = fx[acc]; in_y = 0; in_z = 0; end
      hs = in_valid && in_ready;
      if (hs) acc++;
      @(negedge clk);
    end
    chk("fill_accepted", acc, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_vert_count", vcnt, 12);
    out_ready = 1'b1;
    for (int c = 0; c < 2000 && (popd < 6 || acc < 6); c++) begin
      in_valid = acc < 6;
      if (acc < 6) begin in_x = fx[acc]; in_y = 0; in_z = 0; end
      hs = in_valid && in_ready;
      pp = out_valid && out_ready;
      if (pp) begin
        chk($sformatf("fifo_order%0d", popd), int'($signed(ox)), 321 + popd);
        popd++;
      end
      if (hs) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("drain_popped", popd, 6);
    chk("drain_accepted", acc, 6);

    wr_m33(32'h40000000);
    send(32'h41200000, 32'h41a00000, 32'h0);
    repeat (3) @(negedge clk);
    chk("commit_busy", busy, 1);
    mat_commit = 1'b1;
    @(negedge clk);
    mat_commit = 1'b0;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("commit_idle", busy, 0);
    chk("commit_ready_low", in_ready, 0);
    @(negedge clk);
    chk("commit_ready_high", in_ready, 1);
    wait_out(n);
    chk("old_matrix_x", int'($signed(ox)), 330);
    chk("old_matrix_y", int'($signed(oy)), 260);
    pop;
    send(32'h41200000, 32'h41a00000, 32'h0);
    wait_out(n);
    chk("new_matrix_x", int'($signed(ox)), 325);
    chk("new_matrix_y", int'($signed(oy)), 250);
    pop;

    send(32'h41200000, 32'h41a00000, 32'h0);
    repeat (8) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_vert_count", vcnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_empty", out_valid, 0);
    send(32'h41200000, 32'h41a00000, 32'h0);
    wait_out(n);
    chk("post_reset_x", int'($signed(ox)), 330);
    chk("post_reset_y", int'($signed(oy)), 260);
    chk("post_reset_vert_count", vcnt, 1);
    pop;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
